ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
Parametrised EX/MEM pipeline register for the next-generation core. It carries register-file and HI/LO write-back results from execute to memory access. It adds a per-entry valid bit, a pipeline flush for exceptions, and a loop-back path that preserves multi-cycle execute state (64-bit partial accumulator plus cycle counter, for madd/msub-style ops) while execute is stalled. It also keeps a saturating bubble counter for performance monitoring.

Parameters:
DATA_W, 32, width of general-purpose and HI/LO data
ADDR_W, 5, register-file address width
STALL_W, 6, width of stall vector from pipeline control
STAGE, 3, index of this register's upstream stage bit in stall; STAGE+1 must be < STALL_W
CNT_W, 2, width of multi-cycle op counter
PERF_W, 16, width of bubble counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  exception flush; kills the entry being captured
stall  in  STALL_W  per-stage stall vector, 1 = stop
ex_valid  in  1  execute stage holds a real instruction
ex_wd  in  ADDR_W  destination register address
ex_wreg  in  1  destination register write enable
ex_wdata  in  DATA_W  destination register data
ex_hi  in  DATA_W  HI write value
ex_lo  in  DATA_W  LO write value
ex_whilo  in  1  HI/LO write enable
hilo_i  in  2*DATA_W  multi-cycle partial result from execute
cnt_i  in  CNT_W  multi-cycle cycle index from execute
mem_valid  out  1  registered ex_valid
mem_wd  out  ADDR_W  registered ex_wd
mem_wreg  out  1  registered ex_wreg
mem_wdata  out  DATA_W  registered ex_wdata
mem_hi  out  DATA_W  registered ex_hi
mem_lo  out  DATA_W  registered ex_lo
mem_whilo  out  1  registered ex_whilo
hilo_o  out  2*DATA_W  loop-back partial result to execute
cnt_o  out  CNT_W  loop-back cycle index to execute
bubble_cnt  out  PERF_W  count of bubbles inserted

Behaviour:
- One clock, clk. rst is asynchronous, active-high. While rst=1 all outputs are 0, with no clock required.
- Define s_cur = stall[STAGE] and s_nxt = stall[STAGE+1]. Each rising edge evaluates in this priority order:
  1. flush=1: payload cleared to NOP (valid, wreg, whilo = 0; wd = 0; data = 0). hilo_o and cnt_o cleared to 0. Flush overrides any stall combination.
  2. BUBBLE (s_cur=1, s_nxt=0): payload cleared to NOP as in flush. hilo_o <= hilo_i and cnt_o <= cnt_i, so the stalled multi-cycle op keeps its state. bubble_cnt increments.
  3. ADVANCE (s_cur=0): all mem_* outputs <= corresponding ex_* inputs. hilo_o and cnt_o cleared to 0.
  4. HOLD (s_cur=1, s_nxt=1): every register keeps its value, including hilo_o and cnt_o.
- Latency: 1 cycle, input to output, in ADVANCE.
- Data is not gated by valid. An entry with ex_valid=0 and ex_wreg=1 is passed through as-is; the consumer qualifies on mem_valid.
- bubble_cnt: increments by 1 in BUBBLE only. It saturates at all-ones and never wraps. It is cleared only by rst. Flush and HOLD do not change it.
- Widths are exact and there is no sign extension. hilo_o is {hi_part, lo_part}, passed through as a raw vector.
- rst asserted mid multi-cycle op: everything clears immediately. After release, the first edge follows the normal priority.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle with outputs non-zero -> all outputs 0 before the next edge; bubble_cnt=0.
2. Advance: stall=6'b000000, ex_wd=5'd7, ex_wreg=1, ex_wdata=32'hDEADBEEF, ex_valid=1 -> one edge later mem_wd=7, mem_wdata=DEADBEEF, mem_valid=1; hilo_o=0.
3. Bubble: stall=6'b001111 (s_cur=1, s_nxt=0), hilo_i=64'h0000_0001_0000_0002, cnt_i=2'd1 -> mem_valid=0, mem_wreg=0, hilo_o=64'h0000_0001_0000_0002, cnt_o=1, bubble_cnt=1; then stall=0 -> hilo_o=0, cnt_o=0, ex data captured.
4. Hold: load entry wd=3, then stall=6'b011111 for 3 cycles with changing ex_* and hilo_i -> all outputs unchanged; bubble_cnt unchanged.
5. Flush priority: flush=1 with stall=6'b001111 and with stall=0 -> NOP payload, hilo_o=0, cnt_o=0; bubble_cnt not incremented.
6. Saturation: PERF_W=4, hold BUBBLE condition for 20 cycles -> bubble_cnt reaches 4'hF and stays there.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with flush, bubble insertion, hold,
// multi-cycle accumulator loop-back and a saturating bubble counter.
module ex_mem_stage #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int STAGE   = 3,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic [STALL_W-1:0]  stall,
    input  logic                ex_valid,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic                mem_valid,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic [PERF_W-1:0]   bubble_cnt
);
    logic s_cur, s_nxt, bubble, nop;
    assign s_cur  = stall[STAGE];
    assign s_nxt  = stall[STAGE+1];
    assign bubble = !flush && s_cur && !s_nxt;
    assign nop    = flush || bubble;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid <= 1'b0;
            mem_wd    <= '0;
            mem_wreg  <= 1'b0;
            mem_wdata <= '0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_whilo <= 1'b0;
            hilo_o    <= '0;
            cnt_o     <= '0;
        end else if (nop || !s_cur) begin
            mem_valid <= nop ? 1'b0 : ex_valid;
            mem_wd    <= nop ? '0 : ex_wd;
            mem_wreg  <= nop ? 1'b0 : ex_wreg;
            mem_wdata <= nop ? '0 : ex_wdata;
            mem_hi    <= nop ? '0 : ex_hi;
            mem_lo    <= nop ? '0 : ex_lo;
            mem_whilo <= nop ? 1'b0 : ex_whilo;
            // only a bubble keeps the stalled multi-cycle op's partial state alive
            hilo_o    <= bubble ? hilo_i : '0;
            cnt_o     <= bubble ? cnt_i : '0;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_cnt <= '0;
        else if (bubble && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 1'b1;
    end
endmodule
